hazard_ctrl_param: RTL and testbench
====================================

# hazard_ctrl_param

Parametrised pipeline hazard controller for the 5-stage in-order core, between the decode/execute datapath and the pipeline-register enables. It detects load-use hazards with a configurable load latency, stalls for a multi-cycle execute unit, and flushes younger stages on a control-flow redirect resolved in EX or MEM. It also keeps saturating stall/flush event counters for performance debug.

## Interface
Parameters:
- REG_AW, 5, register-address width; address 0 is the hardwired zero register and never hazards.
- LOAD_LAT, 1, total stall cycles per load-use hazard (1..7).
- REDIRECT_STAGE, 2, stage that resolves branches: 2 = EX (flush IF/ID, ID/EX), 3 = MEM (also flush EX/MEM).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_id, rs2_id  in  REG_AW  source registers of the instruction in ID.
- rs1_used, rs2_used  in  1  the ID instruction actually reads that source.
- idex_rd  in  REG_AW  destination of the instruction in EX.
- idex_mem_read  in  1  the EX instruction is a load.
- redirect  in  1  branch taken or jump resolved in REDIRECT_STAGE this cycle.
- ex_busy  in  1  the multi-cycle EX unit (mul/div) is not done.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_write, ifid_write, idex_write  out  1  register enables.
- ifid_flush, idex_flush, exmem_flush  out  1  synchronous bubble insertion into that register.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Hazard match: hit = idex_mem_read & idex_rd != 0 & ((rs1_used & rs1_id == idex_rd) | (rs2_used & rs2_id == idex_rd)).
- FSM states: RUN, LOAD_WAIT. A down-counter ld_left (3 bits) is used only in LOAD_WAIT.
- Priority each cycle: rst > redirect > ex_busy > load stall (hit in RUN, or LOAD_WAIT).
- redirect: pc_write=1, ifid_write=1, idex_write=1, ifid_flush=1, idex_flush=1, exmem_flush=(REDIRECT_STAGE==3). Next state RUN, ld_left cleared. flush_cnt increments.
- ex_busy (no redirect): pc_write=0, ifid_write=0, idex_write=0, exmem_flush=1, other flushes 0. The FSM state and ld_left hold. stall_cnt increments.
- Load stall: pc_write=0, ifid_write=0, idex_write=1, idex_flush=1. stall_cnt increments.
  - RUN with hit and LOAD_LAT>1: go to LOAD_WAIT with ld_left=LOAD_LAT-1.
  - In LOAD_WAIT, ld_left decrements each cycle; when ld_left==1 at the edge, return to RUN. Matching is ignored in LOAD_WAIT.
- Otherwise (RUN, no event): all writes 1, all flushes 0.
- Counters: add 1 per qualifying cycle and saturate at all-ones. cnt_clr zeroes them and takes priority over increment in the same cycle.

## Timing
- Outputs are combinational (Mealy) from inputs, state and ld_left. There are no registered outputs and zero latency from hit/redirect/ex_busy to the enables.
- Reset (asynchronous):
  - state=RUN, ld_left=0, stall_cnt=0, flush_cnt=0.
  - While rst=1: pc_write=ifid_write=idex_write=0 and ifid_flush=idex_flush=exmem_flush=1.
- Load stall length is exactly LOAD_LAT consecutive cycles, excluding any ex_busy cycles inserted during it.
- redirect arriving mid-LOAD_WAIT aborts the stall in that cycle; the next cycle is RUN.
- redirect and ex_busy together: redirect wins, and ex_busy is re-evaluated next cycle.
- Release of rst mid-stall returns the block to RUN with no residual stall.

## Structure
- Shared package hazard_pkg holds:
  - the state enum (RUN, LOAD_WAIT);
  - constants REDIR_EX=2, REDIR_MEM=3;
  - the default REG_AW.
- Sub-module hazard_match: the parametrised comparator producing hit, which will be reused by the forwarding unit.
- The top level holds the FSM, ld_left and the counters.

## Test plan
- Load x5, then add x6,x5,x1 with LOAD_LAT=1 -> exactly 1 cycle with pc_write=0, idex_flush=1; stall_cnt=1.
- Same sequence with LOAD_LAT=3 -> 3 consecutive stall cycles; state goes RUN -> LOAD_WAIT (ld_left 2 -> 1) -> RUN; stall_cnt=3.
- Load x0 followed by a consumer of x0, or rs2_used=0 on a match -> no stall.
- redirect with REDIRECT_STAGE=3 -> ifid/idex/exmem_flush all 1 for one cycle; flush_cnt=1. The same stimulus with REDIRECT_STAGE=2 -> exmem_flush=0.
- ex_busy for 4 cycles during LOAD_WAIT (ld_left=2) -> 4 freeze cycles with exmem_flush=1, then 2 remaining load-stall cycles.
- redirect in the 2nd LOAD_WAIT cycle -> RUN next cycle.
- rst pulsed mid-stall -> outputs at reset values immediately, RUN after release.
- Counter with CNT_W=2 under 5 stall cycles -> saturates at 3.
- cnt_clr together with an increment -> counter reads 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package hazard_pkg;

  typedef enum logic {
    StRun,
    StLoadWait
  } hz_state_e;

  localparam int unsigned REDIR_EX       = 2;
  localparam int unsigned REDIR_MEM      = 3;
  localparam int unsigned REG_AW_DEFAULT = 5;

endpackage

// File: rtl/hazard_ctrl_param_if.sv
// Datapath-facing signal bundle of the hazard controller: ID/EX operands in, enables and
// counters out.
interface hazard_ctrl_param_if
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEFAULT,
  parameter int unsigned CNT_W  = 16
) ();

  logic [REG_AW-1:0] rs1_id;
  logic [REG_AW-1:0] rs2_id;
  logic              rs1_used;
  logic              rs2_used;
  logic [REG_AW-1:0] idex_rd;
  logic              idex_mem_read;
  logic              redirect;
  logic              ex_busy;
  logic              cnt_clr;

  logic              pc_write;
  logic              ifid_write;
  logic              idex_write;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output rs1_id, rs2_id, rs1_used, rs2_used, idex_rd, idex_mem_read,
    output redirect, ex_busy, cnt_clr,
    input  pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_used, rs2_used, idex_rd, idex_mem_read,
    input  redirect, ex_busy, cnt_clr,
    output pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_match.sv
// Load-use comparator: flags an ID source that reads the destination of a load in EX.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_mem_read,
  output logic              hit
);

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  // Register 0 is hardwired to zero, so a load into it never creates a dependency.
  assign rd_nonzero = (idex_rd != '0);
  assign rs1_hit    = rs1_used && (rs1_id == idex_rd);
  assign rs2_hit    = rs2_used && (rs2_id == idex_rd);
  assign hit        = idex_mem_read && rd_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl_param.sv
// Pipeline hazard controller: load-use stall, multi-cycle EX freeze, redirect flush and
// saturating stall/flush event counters.
module hazard_ctrl_param
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW         = REG_AW_DEFAULT,
  parameter int unsigned LOAD_LAT       = 1,
  parameter int unsigned REDIRECT_STAGE = REDIR_EX,
  parameter int unsigned CNT_W          = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_ctrl_param_if.slave hz
);

  localparam logic [2:0] LdInit = 3'(LOAD_LAT - 1);

  hz_state_e        state_q, state_d;
  logic [2:0]       ld_left_q, ld_left_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hit;
  logic             stall_inc;
  logic             flush_inc;
  logic             pc_write, ifid_write, idex_write;
  logic             ifid_flush, idex_flush, exmem_flush;

  hazard_match #(
    .REG_AW(REG_AW)
  ) u_match (
    .rs1_id       (hz.rs1_id),
    .rs2_id       (hz.rs2_id),
    .rs1_used     (hz.rs1_used),
    .rs2_used     (hz.rs2_used),
    .idex_rd      (hz.idex_rd),
    .idex_mem_read(hz.idex_mem_read),
    .hit          (hit)
  );

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    state_d     = state_q;
    ld_left_d   = ld_left_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = StRun;
      ld_left_d   = '0;
    end else if (hz.redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = (REDIRECT_STAGE == REDIR_MEM);
      state_d     = StRun;
      ld_left_d   = '0;
      flush_inc   = 1'b1;
    end else if (hz.ex_busy) begin
      // Freeze the front end; EX/MEM takes bubbles while the unit grinds. Load stall holds.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_flush = 1'b1;
      stall_inc   = 1'b1;
    end else if (state_q == StLoadWait) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
      if (ld_left_q == 3'd1) begin
        state_d   = StRun;
        ld_left_d = '0;
      end else begin
        ld_left_d = ld_left_q - 3'd1;
      end
    end else if (hit) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d   = StLoadWait;
        ld_left_d = LdInit;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      ld_left_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ld_left_q   <= ld_left_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.idex_write  = idex_write;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Three parameter variants of the hazard controller driven with shared stimulus and
// checked every cycle against a remaining-stall-cycles model.
module tb_hazard_ctrl_param;

  localparam int NI = 3;
  localparam int LAT_P [NI] = '{1, 3, 2};
  localparam int RS_P  [NI] = '{2, 3, 2};
  localparam int CW_P  [NI] = '{16, 16, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1_id = '0, rs2_id = '0, idex_rd = '0;
  logic       rs1_used = 1'b0, rs2_used = 1'b0, idex_mem_read = 1'b0;
  logic       redirect = 1'b0, ex_busy = 1'b0, cnt_clr = 1'b0;

  logic [5:0]  en_act [NI];
  logic [15:0] sc_act [NI];
  logic [15:0] fc_act [NI];

  int checks = 0;
  int errors = 0;

  int m_left [NI] = '{0, 0, 0};
  int m_sc   [NI] = '{0, 0, 0};
  int m_fc   [NI] = '{0, 0, 0};
  int nx_left[NI] = '{0, 0, 0};
  int nx_sc  [NI] = '{0, 0, 0};
  int nx_fc  [NI] = '{0, 0, 0};

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    hazard_ctrl_param_if #(.REG_AW(5), .CNT_W(CW_P[gi])) bus ();
    assign bus.rs1_id        = rs1_id;
    assign bus.rs2_id        = rs2_id;
    assign bus.rs1_used      = rs1_used;
    assign bus.rs2_used      = rs2_used;
    assign bus.idex_rd       = idex_rd;
    assign bus.idex_mem_read = idex_mem_read;
    assign bus.redirect      = redirect;
    assign bus.ex_busy       = ex_busy;
    assign bus.cnt_clr       = cnt_clr;

    hazard_ctrl_param #(
      .REG_AW        (5),
      .LOAD_LAT      (LAT_P[gi]),
      .REDIRECT_STAGE(RS_P[gi]),
      .CNT_W         (CW_P[gi])
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .hz (bus.slave)
    );

    assign en_act[gi] = {bus.pc_write, bus.ifid_write, bus.idex_write,
                         bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
    assign sc_act[gi] = 16'(bus.stall_cnt);
    assign fc_act[gi] = 16'(bus.flush_cnt);
  end

  task automatic chk(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t actual=%0h required=%0h", name, i, $time, act, exp);
    end
  endtask

  // Per-cycle reference: outputs follow the event priority, stall length is tracked as a
  // plain count of load-stall cycles still owed.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [5:0] e;
      bit         h, st, fl;
      int         nl, mx;
      h  = idex_mem_read && (idex_rd != 0) &&
           ((rs1_used && rs1_id == idex_rd) || (rs2_used && rs2_id == idex_rd));
      st = 0;
      fl = 0;
      nl = m_left[i];
      mx = (1 << CW_P[i]) - 1;
      if (rst) begin
        e  = 6'b000111;
        nl = 0;
      end else if (redirect) begin
        e  = {5'b11111, RS_P[i] == 3};
        nl = 0;
        fl = 1;
      end else if (ex_busy) begin
        e  = 6'b000001;
        st = 1;
      end else if (m_left[i] > 0) begin
        e  = 6'b001010;
        nl = m_left[i] - 1;
        st = 1;
      end else if (h) begin
        e  = 6'b001010;
        nl = LAT_P[i] - 1;
        st = 1;
      end else begin
        e  = 6'b111000;
      end
      chk("enables", i, int'(en_act[i]), int'(e));
      chk("stall_cnt", i, int'(sc_act[i]), rst ? 0 : m_sc[i]);
      chk("flush_cnt", i, int'(fc_act[i]), rst ? 0 : m_fc[i]);
      nx_left[i] = nl;
      if (rst || cnt_clr) begin
        nx_sc[i] = 0;
        nx_fc[i] = 0;
      end else begin
        nx_sc[i] = (st && m_sc[i] < mx) ? m_sc[i] + 1 : m_sc[i];
        nx_fc[i] = (fl && m_fc[i] < mx) ? m_fc[i] + 1 : m_fc[i];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      m_left[i] <= nx_left[i];
      m_sc[i]   <= nx_sc[i];
      m_fc[i]   <= nx_fc[i];
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    rs1_id = '0; rs2_id = '0; rs1_used = 0; rs2_used = 0;
    idex_rd = '0; idex_mem_read = 0; redirect = 0; ex_busy = 0; cnt_clr = 0;
  endtask

  // Load x5 in EX, add x6,x5,x1 in ID.
  task automatic load_use();
    idex_mem_read = 1; idex_rd = 5'd5;
    rs1_id = 5'd5; rs1_used = 1; rs2_id = 5'd1; rs2_used = 1;
  endtask

  initial begin
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_enables", i, int'(en_act[i]), 6'b000111);
      chk("rst_stall_cnt", i, int'(sc_act[i]), 0);
    end
    step(2);
    rst = 0;
    step(1);

    load_use();
    #1;
    chk("lu_pc_write", 0, int'(en_act[0][5]), 0);
    chk("lu_idex_flush", 0, int'(en_act[0][1]), 1);
    step(1);
    idle();
    step(5);
    chk("lu_total", 0, int'(sc_act[0]), 1);
    chk("lu_total", 1, int'(sc_act[1]), 3);
    chk("lu_total", 2, int'(sc_act[2]), 2);

    idex_mem_read = 1; idex_rd = 5'd0; rs1_id = 5'd0; rs1_used = 1;
    #1;
    chk("x0_nostall", 1, int'(en_act[1]), 6'b111000);
    idex_rd = 5'd7; rs1_id = 5'd3; rs2_id = 5'd7; rs2_used = 0;
    #1;
    chk("rs2_unused_nostall", 1, int'(en_act[1]), 6'b111000);
    step(1);
    idle();

    redirect = 1;
    #1;
    chk("redir_ex_exmem", 0, int'(en_act[0][0]), 0);
    chk("redir_mem_exmem", 1, int'(en_act[1]), 6'b111111);
    step(1);
    idle();
    #1;
    for (int i = 0; i < NI; i++) chk("redir_flush_cnt", i, int'(fc_act[i]), 1);

    cnt_clr = 1;
    step(1);
    idle();
    load_use();
    step(1);
    idle();
    ex_busy = 1;
    #1;
    chk("busy_freeze", 1, int'(en_act[1]), 6'b000001);
    step(4);
    ex_busy = 0;
    #1;
    chk("after_busy_stall", 1, int'(en_act[1]), 6'b001010);
    step(4);
    chk("busy_total", 0, int'(sc_act[0]), 5);
    chk("busy_total", 1, int'(sc_act[1]), 7);
    chk("saturated", 2, int'(sc_act[2]), 3);

    ex_busy = 1; cnt_clr = 1;
    step(1);
    idle();
    for (int i = 0; i < NI; i++) chk("clr_wins", i, int'(sc_act[i]), 0);

    load_use();
    step(1);
    idle();
    step(1);
    redirect = 1;
    step(1);
    idle();
    #1;
    chk("redir_abort_run", 1, int'(en_act[1]), 6'b111000);

    load_use();
    step(1);
    idle();
    rst = 1;
    #1;
    chk("rst_mid_stall", 1, int'(en_act[1]), 6'b000111);
    step(1);
    rst = 0;
    #1;
    chk("rst_release_run", 1, int'(en_act[1]), 6'b111000);
    step(1);

    for (int c = 0; c < 3000; c++) begin
      rs1_id        = 5'($urandom_range(0, 3));
      rs2_id        = 5'($urandom_range(0, 3));
      idex_rd       = 5'($urandom_range(0, 3));
      rs1_used      = 1'($urandom_range(0, 1));
      rs2_used      = 1'($urandom_range(0, 1));
      idex_mem_read = ($urandom_range(0, 2) == 0);
      redirect      = ($urandom_range(0, 9) == 0);
      ex_busy       = ($urandom_range(0, 5) == 0);
      cnt_clr       = ($urandom_range(0, 39) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 0;
    idle();
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
